lsu_bus_if: RTL and testbench
=============================

Name: lsu_bus_if

Overview:
- Load/store unit between the execute stage and the data-memory bus.
- Consumes the decoder's memory controls: ld_en (wbCtrl==01), st_en (memWR) and the 3-bit mem_ctrl code.
- Drives a single-outstanding req/ack memory bus, generates byte strobes, and aligns and extends load data.
- Stalls the pipeline while a transaction is in flight and flags misaligned or illegal accesses.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.
- TIMEOUT_CYCLES, 16, ack wait limit; used only when LSU_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ld_en  in  1  load instruction present this cycle.
- st_en  in  1  store instruction present this cycle.
- mem_ctrl  in  3  000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 101 SB, 110 SH, 111 SW.
- addr  in  XLEN  effective address from the ALU.
- st_data  in  XLEN  rs2 value.
- stall  out  1  hold the pipeline.
- ld_data  out  XLEN  aligned, extended load result.
- ld_valid  out  1  one-cycle pulse; ld_data is valid.
- err  out  1  one-cycle pulse for a misaligned or illegal access.
- bus_req  out  1  bus request.
- bus_we  out  1  1 = write.
- bus_addr  out  XLEN  word address, bits [1:0] = 00.
- bus_wdata  out  XLEN  lane-replicated write data.
- bus_strb  out  4  byte enables.
- bus_rdata  in  XLEN  read data, valid with bus_ack.
- bus_ack  in  1  transaction complete.

Behaviour:
- Reset: all outputs 0; state IDLE. Asserting rst mid-transaction drops bus_req asynchronously and abandons the access.
- States: IDLE, BUSY, RESP.
- An op is accepted in IDLE or RESP when ld_en|st_en is high.
- Illegal combinations:
  - ld_en with code 101-111.
  - st_en with code 000-100.
  - ld_en and st_en both high.
- Misaligned accesses:
  - H (halfword): addr[0] != 0.
  - W (word): addr[1:0] != 00.
- An illegal or misaligned op:
  - issues no bus request and does not stall;
  - err=1 on the next cycle;
  - state goes to IDLE.
- A legal op:
  - registers bus_addr={addr[31:2],00}, we, strb, wdata, code and addr[1:0];
  - goes to BUSY;
  - stall is high combinationally in the accept cycle.
- Strobes and write data:
  - SB: strb = 0001 << addr[1:0], wdata = byte replicated x4.
  - SH: strb = 0011 << addr[1:0], wdata = halfword replicated x2.
  - SW: strb = 1111, wdata = st_data.
  - Loads: strb = 1111, we = 0.
- BUSY:
  - bus_req=1; addr, we, wdata and strb are held stable until bus_ack.
  - stall=1.
  - On bus_ack: loads capture the extracted and extended bus_rdata into ld_data; go to RESP.
- RESP (one cycle):
  - stall=0.
  - ld_valid=1 for loads, 0 for stores.
  - A new op may be accepted, giving back-to-back operation; otherwise go to IDLE.
  - ld_data holds its value until the next load completes.
- Minimum latency: accept at cycle 0, bus_req at cycle 1, ack at cycle 1, ld_valid at cycle 2.
- Load extraction:
  - Byte lane = addr[1:0]; halfword lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Ignored inputs:
  - bus_ack outside BUSY.
  - ld_en/st_en while in BUSY; the pipeline is stalled and holds them.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - A cycle counter is cleared on entry to BUSY.
  - If the count reaches TIMEOUT_CYCLES without bus_ack: drop bus_req, pulse err for one cycle, ld_valid=0, return to IDLE.
  - An ack in the same cycle as the limit wins.
- Undefined: no counter; BUSY waits indefinitely for bus_ack.

Decomposition:
- Shared package lsu_pkg contains:
  - enum mem_ctrl_e with the encodings listed above;
  - enum lsu_state_e {IDLE, BUSY, RESP};
  - constants for strobe masks.
- Sub-module lsu_load_align: purely combinational lane select plus sign/zero extension (code, addr[1:0], rdata -> ld_data). It is instantiated once and unit-testable alone.

Test Plan:
- LW, addr=0x104, ack in 1st BUSY cycle, rdata=0xDEADBEEF -> bus_addr=0x104, strb=1111, stall for 2 cycles, ld_valid at cycle 2, ld_data=0xDEADBEEF.
- LB/LBU, addr=0x103, rdata=0x80FF1234 -> LB returns 0xFFFFFF80, LBU returns 0x00000080.
- SH, addr=0x202, st_data=0x0000ABCD -> bus_we=1, strb=1100, wdata=0xABCDABCD, ld_valid=0.
- LW, addr=0x101 (misaligned) -> no bus_req, stall=0, err pulse 1 cycle; the same holds for st_en with code 010.
- Ack delayed 5 cycles, with rst asserted during cycle 3 of BUSY -> bus_req, stall and ld_valid go to 0 immediately; IDLE after reset is released.
- Timeout (LSU_TIMEOUT_EN defined): no ack for 16 cycles -> err pulse, bus_req=0, stall released. A back-to-back LW then SW with ack at cycle 1 each -> the second op is accepted in RESP with no idle gap.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: memory-control codes,
// FSM states, byte-strobe masks and small code-classification helpers.
package lsu_pkg;

  typedef enum logic [2:0] {
    MC_LB  = 3'b000,
    MC_LH  = 3'b001,
    MC_LW  = 3'b010,
    MC_LBU = 3'b011,
    MC_LHU = 3'b100,
    MC_SB  = 3'b101,
    MC_SH  = 3'b110,
    MC_SW  = 3'b111
  } mem_ctrl_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } lsu_state_e;

  localparam logic [3:0] STRB_BYTE = 4'b0001;
  localparam logic [3:0] STRB_HALF = 4'b0011;
  localparam logic [3:0] STRB_WORD = 4'b1111;

  // Codes 101..111 are the store encodings; everything below is a load.
  function automatic logic isStoreCode(input logic [2:0] code);
    return code >= MC_SB;
  endfunction

  function automatic logic isHalfCode(input logic [2:0] code);
    return (code == MC_LH) || (code == MC_LHU) || (code == MC_SH);
  endfunction

  function automatic logic isWordCode(input logic [2:0] code);
    return (code == MC_LW) || (code == MC_SW);
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load-data alignment: picks the byte/halfword lane from the
// bus word and applies sign or zero extension according to the load code.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_code,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (i_lane)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    o_data = i_rdata;
    case (i_code)
      MC_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      MC_LH:   o_data = {{16{w_half[15]}}, w_half};
      MC_LBU:  o_data = {24'h000000, w_byte};
      MC_LHU:  o_data = {16'h0000, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_bus_if.sv
// Load/store unit bridging the execute stage to a single-outstanding req/ack
// data bus. Optional ack watchdog is enabled by defining LSU_TIMEOUT_EN.
module lsu_bus_if
  import lsu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ld_en,
  input  logic            st_en,
  input  logic [2:0]      mem_ctrl,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] st_data,
  output logic            stall,
  output logic [XLEN-1:0] ld_data,
  output logic            ld_valid,
  output logic            err,
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  output logic [3:0]      bus_strb,
  input  logic [XLEN-1:0] bus_rdata,
  input  logic            bus_ack
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_BUSY = BUSY;
  localparam logic [1:0] S_RESP = RESP;

  if (XLEN != 32 || TIMEOUT_CYCLES < 1) begin : g_paramCheck
    $error("lsu_bus_if: XLEN must be 32 and TIMEOUT_CYCLES at least 1");
  end

  logic [1:0]      r_state;
  logic [1:0]      w_nextState;
  logic            r_we;
  logic [2:0]      r_code;
  logic [1:0]      r_lane;
  logic [XLEN-1:0] r_busAddr;
  logic [XLEN-1:0] r_wdata;
  logic [3:0]      r_strb;
  logic [XLEN-1:0] r_ldData;
  logic            r_ldValid;
  logic            r_err;

  logic            w_canAccept;
  logic            w_accept;
  logic            w_illegal;
  logic            w_misaligned;
  logic            w_start;
  logic            w_ack;
  logic            w_timeout;
  logic [3:0]      w_strb;
  logic [XLEN-1:0] w_wdata;
  logic [XLEN-1:0] w_alignData;

  // Reset masks acceptance so stall stays low while rst is held.
  assign w_canAccept  = (r_state == S_IDLE) || (r_state == S_RESP);
  assign w_accept     = !rst && w_canAccept && (ld_en || st_en);
  assign w_illegal    = (ld_en && st_en)
                     || (ld_en && isStoreCode(mem_ctrl))
                     || (st_en && !isStoreCode(mem_ctrl));
  assign w_misaligned = (isHalfCode(mem_ctrl) && addr[0])
                     || (isWordCode(mem_ctrl) && (addr[1:0] != 2'b00));
  assign w_start      = w_accept && !w_illegal && !w_misaligned;
  assign w_ack        = (r_state == S_BUSY) && bus_ack;

  always_comb begin
    w_strb  = STRB_WORD;
    w_wdata = st_data;
    case (mem_ctrl)
      MC_SB: begin
        w_strb  = STRB_BYTE << addr[1:0];
        w_wdata = {4{st_data[7:0]}};
      end
      MC_SH: begin
        w_strb  = STRB_HALF << addr[1:0];
        w_wdata = {2{st_data[15:0]}};
      end
      default: begin
        w_strb  = STRB_WORD;
        w_wdata = st_data;
      end
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_waitCnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_waitCnt <= '0;
    end else if (w_start) begin
      r_waitCnt <= '0;
    end else if (r_state == S_BUSY) begin
      r_waitCnt <= r_waitCnt + CNT_W'(1);
    end
  end

  // An ack arriving on the limit cycle takes priority over the timeout.
  assign w_timeout = (r_state == S_BUSY) && !bus_ack
                  && (r_waitCnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_BUSY: begin
        if (bus_ack) begin
          w_nextState = S_RESP;
        end else if (w_timeout) begin
          w_nextState = S_IDLE;
        end
      end
      default: w_nextState = w_start ? S_BUSY : S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_we      <= 1'b0;
      r_code    <= 3'b000;
      r_lane    <= 2'b00;
      r_busAddr <= '0;
      r_wdata   <= '0;
      r_strb    <= 4'b0000;
      r_ldData  <= '0;
      r_ldValid <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_err     <= (w_accept && !w_start) || w_timeout;
      r_ldValid <= w_ack && !r_we;
      if (w_start) begin
        r_busAddr <= {addr[XLEN-1:2], 2'b00};
        r_we      <= st_en;
        r_strb    <= w_strb;
        r_wdata   <= w_wdata;
        r_code    <= mem_ctrl;
        r_lane    <= addr[1:0];
      end
      if (w_ack && !r_we) begin
        r_ldData <= w_alignData;
      end
    end
  end

  lsu_load_align u_loadAlign (
    .i_code  (r_code),
    .i_lane  (r_lane),
    .i_rdata (bus_rdata),
    .o_data  (w_alignData)
  );

  assign stall     = (r_state == S_BUSY) || w_start;
  assign bus_req   = (r_state == S_BUSY);
  assign bus_we    = r_we;
  assign bus_addr  = r_busAddr;
  assign bus_wdata = r_wdata;
  assign bus_strb  = r_strb;
  assign ld_data   = r_ldData;
  assign ld_valid  = r_ldValid;
  assign err       = r_err;

endmodule

// File: tb/tb_lsu_bus_if.sv
// Self-checking bench for lsu_bus_if: directed cases plus randomized ops
// compared against a byte/lane arithmetic reference model.
module tb_lsu_bus_if;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ld_en = 1'b0;
  logic        st_en = 1'b0;
  logic [2:0]  mem_ctrl = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] st_data = 32'h0;
  logic        stall;
  logic [31:0] ld_data;
  logic        ld_valid;
  logic        err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_strb;
  logic [31:0] bus_rdata = 32'h0;
  logic        bus_ack = 1'b0;

  int total = 0;
  int bad = 0;
  logic [31:0] expLdData = 32'h0;

  logic        obsStall0, obsReq1, obsErr1, obsErrResp, obsWe;
  logic        obsLdValid, obsStallResp, obsLdValidAfter;
  logic [31:0] obsAddr, obsWdata, obsLdData;
  logic [3:0]  obsStrb;
  bit          obsHeld;
  int          obsStallCycles;

  always #5 clk = ~clk;

  lsu_bus_if dut (
    .clk       (clk),
    .rst       (rst),
    .ld_en     (ld_en),
    .st_en     (st_en),
    .mem_ctrl  (mem_ctrl),
    .addr      (addr),
    .st_data   (st_data),
    .stall     (stall),
    .ld_data   (ld_data),
    .ld_valid  (ld_valid),
    .err       (err),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_strb  (bus_strb),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack)
  );

  // Reference model: access size in bytes for each code.
  function automatic int accessSize(input logic [2:0] code);
    case (code)
      3'd0, 3'd3, 3'd5: return 1;
      3'd1, 3'd4, 3'd6: return 2;
      default:          return 4;
    endcase
  endfunction

  function automatic bit modelLegal(input bit ld, input bit st, input logic [2:0] code,
                                    input logic [31:0] a);
    if (ld == st) return 1'b0;
    if (ld && code > 3'd4) return 1'b0;
    if (st && code < 3'd5) return 1'b0;
    return (a % accessSize(code)) == 0;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [2:0] code, input logic [31:0] a,
                                            input logic [31:0] rd);
    int size;
    logic [31:0] mask, v;
    size = accessSize(code);
    if (size == 4) return rd;
    mask = (size == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
    v = (rd >> (8 * (a % 4))) & mask;
    if ((code == 3'd0 || code == 3'd1) && v > (mask >> 1)) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [3:0] modelStrb(input logic [2:0] code, input logic [31:0] a);
    int size;
    size = accessSize(code);
    if (code < 3'd5 || size == 4) return 4'hF;
    return 4'(((1 << size) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] modelWdata(input logic [2:0] code, input logic [31:0] d);
    case (accessSize(code))
      1:       return (d & 32'hFF) * 32'h0101_0101;
      2:       return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  // Drives one op, services the bus with the given ack delay and records what the DUT showed.
  task automatic applyStimulus(input bit ld, input bit st, input logic [2:0] code,
                               input logic [31:0] a, input logic [31:0] d,
                               input int ackDelay, input logic [31:0] rd);
    @(posedge clk); #1;
    ld_en = ld; st_en = st; mem_ctrl = code; addr = a; st_data = d;
    @(negedge clk);
    obsStall0 = stall;
    obsStallCycles = stall ? 1 : 0;
    @(posedge clk); #1;
    ld_en = 1'b0; st_en = 1'b0;
    mem_ctrl = 3'($urandom); addr = $urandom; st_data = $urandom;
    obsReq1 = bus_req; obsErr1 = err; obsAddr = bus_addr; obsWe = bus_we;
    obsStrb = bus_strb; obsWdata = bus_wdata;
    obsHeld = 1'b1;
    if (bus_req) begin
      for (int i = 0; i <= ackDelay; i++) begin
        if (i == ackDelay) begin
          bus_ack = 1'b1; bus_rdata = rd;
        end
        @(negedge clk);
        if (!stall || !bus_req || bus_addr !== obsAddr || bus_we !== obsWe ||
            bus_strb !== obsStrb || bus_wdata !== obsWdata) obsHeld = 1'b0;
        obsStallCycles++;
        @(posedge clk); #1;
      end
      bus_ack = 1'b0; bus_rdata = $urandom;
    end else begin
      bus_ack = 1'b1; bus_rdata = $urandom;
      @(posedge clk); #1;
      bus_ack = 1'b0;
    end
    @(negedge clk);
    obsErrResp = err; obsLdValid = ld_valid; obsLdData = ld_data; obsStallResp = stall;
    @(posedge clk); #1;
    @(negedge clk);
    obsLdValidAfter = ld_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1; ld_en = 1'b1; mem_ctrl = 3'd2; addr = 32'h100;
    #12;
    total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL rst_stall got=%b want=0", stall); end
    total++; if (ld_data !== 32'h0) begin bad++; $display("[TB] FAIL rst_ld_data got=%h want=0", ld_data); end
    total++; if (ld_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_ld_valid got=%b want=0", ld_valid); end
    total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL rst_err got=%b want=0", err); end
    total++; if (bus_req !== 1'b0) begin bad++; $display("[TB] FAIL rst_bus_req got=%b want=0", bus_req); end
    total++; if (bus_we !== 1'b0) begin bad++; $display("[TB] FAIL rst_bus_we got=%b want=0", bus_we); end
    total++; if (bus_addr !== 32'h0) begin bad++; $display("[TB] FAIL rst_bus_addr got=%h want=0", bus_addr); end
    total++; if (bus_wdata !== 32'h0) begin bad++; $display("[TB] FAIL rst_bus_wdata got=%h want=0", bus_wdata); end
    total++; if (bus_strb !== 4'h0) begin bad++; $display("[TB] FAIL rst_bus_strb got=%b want=0", bus_strb); end
    ld_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    expLdData = 32'h0;
  endtask

  task automatic test_directed();
    applyStimulus(1, 0, 3'd2, 32'h104, 32'h0, 0, 32'hDEADBEEF);
    expLdData = 32'hDEADBEEF;
    total++; if (obsAddr !== 32'h104) begin bad++; $display("[TB] FAIL lw_addr got=%h want=104", obsAddr); end
    total++; if (obsStrb !== 4'hF) begin bad++; $display("[TB] FAIL lw_strb got=%b want=1111", obsStrb); end
    total++; if (obsWe !== 1'b0) begin bad++; $display("[TB] FAIL lw_we got=%b want=0", obsWe); end
    total++; if (obsStallCycles != 2) begin bad++; $display("[TB] FAIL lw_stall_cycles got=%0d want=2", obsStallCycles); end
    total++; if (obsLdValid !== 1'b1) begin bad++; $display("[TB] FAIL lw_ld_valid got=%b want=1", obsLdValid); end
    total++; if (obsStallResp !== 1'b0) begin bad++; $display("[TB] FAIL lw_resp_stall got=%b want=0", obsStallResp); end
    total++; if (obsLdData !== expLdData) begin bad++; $display("[TB] FAIL lw_data got=%h want=%h", obsLdData, expLdData); end
    total++; if (obsLdValidAfter !== 1'b0) begin bad++; $display("[TB] FAIL lw_valid_pulse got=%b want=0", obsLdValidAfter); end

    applyStimulus(1, 0, 3'd0, 32'h103, 32'h0, 1, 32'h80FF1234);
    total++; if (obsAddr !== 32'h100) begin bad++; $display("[TB] FAIL lb_addr got=%h want=100", obsAddr); end
    total++; if (obsLdData !== 32'hFFFFFF80) begin bad++; $display("[TB] FAIL lb_data got=%h want=ffffff80", obsLdData); end
    applyStimulus(1, 0, 3'd3, 32'h103, 32'h0, 0, 32'h80FF1234);
    total++; if (obsLdData !== 32'h00000080) begin bad++; $display("[TB] FAIL lbu_data got=%h want=00000080", obsLdData); end
    expLdData = 32'h00000080;

    applyStimulus(0, 1, 3'd6, 32'h202, 32'h0000ABCD, 2, 32'h0);
    total++; if (obsWe !== 1'b1) begin bad++; $display("[TB] FAIL sh_we got=%b want=1", obsWe); end
    total++; if (obsStrb !== 4'b1100) begin bad++; $display("[TB] FAIL sh_strb got=%b want=1100", obsStrb); end
    total++; if (obsWdata !== 32'hABCDABCD) begin bad++; $display("[TB] FAIL sh_wdata got=%h want=abcdabcd", obsWdata); end
    total++; if (obsLdValid !== 1'b0) begin bad++; $display("[TB] FAIL sh_ld_valid got=%b want=0", obsLdValid); end
    total++; if (obsLdData !== expLdData) begin bad++; $display("[TB] FAIL sh_ld_hold got=%h want=%h", obsLdData, expLdData); end

    for (int k = 0; k < 2; k++) begin
      if (k == 0) applyStimulus(1, 0, 3'd2, 32'h101, 32'h0, 0, 32'h0);
      else        applyStimulus(0, 1, 3'd2, 32'h200, 32'h12345678, 0, 32'h0);
      total++; if (obsReq1 !== 1'b0) begin bad++; $display("[TB] FAIL bad_op%0d_req got=%b want=0", k, obsReq1); end
      total++; if (obsStall0 !== 1'b0) begin bad++; $display("[TB] FAIL bad_op%0d_stall got=%b want=0", k, obsStall0); end
      total++; if (obsErr1 !== 1'b1) begin bad++; $display("[TB] FAIL bad_op%0d_err got=%b want=1", k, obsErr1); end
      total++; if (obsErrResp !== 1'b0) begin bad++; $display("[TB] FAIL bad_op%0d_err_pulse got=%b want=0", k, obsErrResp); end
      total++; if (obsLdValid !== 1'b0) begin bad++; $display("[TB] FAIL bad_op%0d_ld_valid got=%b want=0", k, obsLdValid); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, sd;
    rd = $urandom; sd = $urandom;
    @(posedge clk); #1;
    ld_en = 1'b1; mem_ctrl = 3'd2; addr = 32'h300;
    @(posedge clk); #1;
    ld_en = 1'b0; bus_ack = 1'b1; bus_rdata = rd;
    @(posedge clk); #1;
    bus_ack = 1'b0; st_en = 1'b1; mem_ctrl = 3'd7; addr = 32'h304; st_data = sd;
    @(negedge clk);
    total++; if (ld_valid !== 1'b1) begin bad++; $display("[TB] FAIL b2b_ld_valid got=%b want=1", ld_valid); end
    total++; if (ld_data !== rd) begin bad++; $display("[TB] FAIL b2b_ld_data got=%h want=%h", ld_data, rd); end
    @(posedge clk); #1;
    st_en = 1'b0;
    total++; if (bus_req !== 1'b1) begin bad++; $display("[TB] FAIL b2b_no_gap got=%b want=1", bus_req); end
    total++; if (bus_we !== 1'b1) begin bad++; $display("[TB] FAIL b2b_we got=%b want=1", bus_we); end
    total++; if (bus_addr !== 32'h304) begin bad++; $display("[TB] FAIL b2b_addr got=%h want=304", bus_addr); end
    total++; if (bus_wdata !== sd) begin bad++; $display("[TB] FAIL b2b_wdata got=%h want=%h", bus_wdata, sd); end
    bus_ack = 1'b1;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(negedge clk);
    total++; if (ld_valid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_st_ld_valid got=%b want=0", ld_valid); end
    total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL b2b_stall got=%b want=0", stall); end
    expLdData = rd;
  endtask

  task automatic test_reset_midflight();
    @(posedge clk); #1;
    ld_en = 1'b1; mem_ctrl = 3'd2; addr = 32'h400;
    @(posedge clk); #1;
    ld_en = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    total++; if (bus_req !== 1'b1) begin bad++; $display("[TB] FAIL mid_req_before got=%b want=1", bus_req); end
    #2 rst = 1'b1;
    #1;
    total++; if (bus_req !== 1'b0) begin bad++; $display("[TB] FAIL mid_req_async got=%b want=0", bus_req); end
    total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL mid_stall_async got=%b want=0", stall); end
    total++; if (ld_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_ld_valid got=%b want=0", ld_valid); end
    @(posedge clk); #1;
    rst = 1'b0;
    expLdData = 32'h0;
    bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
    @(negedge clk);
    total++; if (bus_req !== 1'b0 || stall !== 1'b0) begin bad++; $display("[TB] FAIL mid_idle got=%b%b want=00", bus_req, stall); end
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(negedge clk);
    total++; if (ld_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_late_ack got=%b want=0", ld_valid); end
    total++; if (ld_data !== expLdData) begin bad++; $display("[TB] FAIL mid_ld_data got=%h want=%h", ld_data, expLdData); end
  endtask

  task automatic test_random();
    bit ld, st, legal;
    int kind, dly;
    logic [2:0] code;
    logic [31:0] a, d, rd;
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 9);
      ld = (kind < 5) || (kind == 9);
      st = (kind >= 5);
      if ($urandom_range(0, 3) == 0) code = 3'($urandom_range(0, 7));
      else code = ld ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      d = $urandom; rd = $urandom; dly = $urandom_range(0, 3);
      legal = modelLegal(ld, st, code, a);
      applyStimulus(ld, st, code, a, d, dly, rd);
      if (legal && ld) expLdData = modelLoad(code, a, rd);
      total++; if (obsStall0 !== legal) begin bad++; $display("[TB] FAIL rnd%0d_stall got=%b want=%b", n, obsStall0, legal); end
      total++; if (obsReq1 !== legal) begin bad++; $display("[TB] FAIL rnd%0d_req got=%b want=%b", n, obsReq1, legal); end
      total++; if (obsErr1 !== !legal) begin bad++; $display("[TB] FAIL rnd%0d_err got=%b want=%b", n, obsErr1, !legal); end
      total++; if (obsErrResp !== 1'b0) begin bad++; $display("[TB] FAIL rnd%0d_err_pulse got=%b want=0", n, obsErrResp); end
      total++; if (obsLdValid !== (legal && ld)) begin bad++; $display("[TB] FAIL rnd%0d_ld_valid got=%b want=%b", n, obsLdValid, legal && ld); end
      total++; if (obsLdData !== expLdData) begin bad++; $display("[TB] FAIL rnd%0d_ld_data got=%h want=%h", n, obsLdData, expLdData); end
      if (legal) begin
        total++; if (obsAddr !== (a & 32'hFFFF_FFFC)) begin bad++; $display("[TB] FAIL rnd%0d_addr got=%h want=%h", n, obsAddr, a & 32'hFFFF_FFFC); end
        total++; if (obsWe !== st) begin bad++; $display("[TB] FAIL rnd%0d_we got=%b want=%b", n, obsWe, st); end
        total++; if (obsStrb !== modelStrb(code, a)) begin bad++; $display("[TB] FAIL rnd%0d_strb got=%b want=%b", n, obsStrb, modelStrb(code, a)); end
        total++; if (obsHeld !== 1'b1) begin bad++; $display("[TB] FAIL rnd%0d_held got=%b want=1", n, obsHeld); end
        total++; if (obsStallCycles != dly + 2) begin bad++; $display("[TB] FAIL rnd%0d_stall_cycles got=%0d want=%0d", n, obsStallCycles, dly + 2); end
        if (st) begin
          total++; if (obsWdata !== modelWdata(code, d)) begin bad++; $display("[TB] FAIL rnd%0d_wdata got=%h want=%h", n, obsWdata, modelWdata(code, d)); end
        end
      end
    end
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    int reqCycles;
    reqCycles = 0;
    @(posedge clk); #1;
    ld_en = 1'b1; mem_ctrl = 3'd2; addr = 32'h500;
    @(posedge clk); #1;
    ld_en = 1'b0;
    while (bus_req && reqCycles < 40) begin
      reqCycles++;
      @(posedge clk); #1;
    end
    total++; if (reqCycles != 16) begin bad++; $display("[TB] FAIL to_req_cycles got=%0d want=16", reqCycles); end
    total++; if (err !== 1'b1) begin bad++; $display("[TB] FAIL to_err got=%b want=1", err); end
    total++; if (stall !== 1'b0) begin bad++; $display("[TB] FAIL to_stall got=%b want=0", stall); end
    total++; if (ld_valid !== 1'b0) begin bad++; $display("[TB] FAIL to_ld_valid got=%b want=0", ld_valid); end
    @(posedge clk); #1;
    total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL to_err_pulse got=%b want=0", err); end
  endtask
`endif

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired before the test sequence completed");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midflight();
    test_random();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
